// File: rtl/inbuff_tile_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inbuff_tile_sched_pkg
// Purpose  : Shared encodings for the inbuff tile scheduler (FSM, bank states).
// Revision : 1.0 - initial release
// ============================================================================
package inbuff_tile_sched_pkg;

    localparam int MAX_TILES = 32;

    typedef enum logic [1:0] {
        BANK_EMPTY     = 2'd0,
        BANK_LOADING   = 2'd1,
        BANK_FULL      = 2'd2,
        BANK_COMPUTING = 2'd3
    } bank_state_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } fsm_state_t;

endpackage
`default_nettype wire

// File: rtl/inbuff_bank_state.sv
`default_nettype none
// ============================================================================
// Module   : inbuff_bank_state
// Purpose  : Life-cycle tracker for one inbuff bank (EMPTY/LOADING/FULL/COMPUTING).
// Revision : 1.0 - initial release
// ============================================================================
module inbuff_bank_state
    import inbuff_tile_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        load_accept,
    input  logic        load_complete,
    input  logic        comp_start,
    input  logic        comp_done,
    output bank_state_t state
);

    bank_state_t r_state;

    // Each event is only honoured in the one state where it is legal.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= BANK_EMPTY;
        end else begin
            case (r_state)
                BANK_EMPTY:     if (load_accept)   r_state <= BANK_LOADING;
                BANK_LOADING:   if (load_complete) r_state <= BANK_FULL;
                BANK_FULL:      if (comp_start)    r_state <= BANK_COMPUTING;
                BANK_COMPUTING: if (comp_done)     r_state <= BANK_EMPTY;
                default:                           r_state <= BANK_EMPTY;
            endcase
        end
    end

    assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/inbuff_tile_sched.sv
`default_nettype none
// ============================================================================
// Module   : inbuff_tile_sched
// Purpose  : Ping-pong inbuff scheduler: issues DMA tile loads and hands full
//            banks to the address generator, one layer per start.
// Revision : 1.0 - initial release
// ============================================================================
module inbuff_tile_sched
    import inbuff_tile_sched_pkg::*;
#(
    parameter int TILE_W = 5
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [TILE_W:0]   cfg_tile_total,
    output logic              load_req,
    output logic              load_bank,
    output logic [TILE_W-1:0] load_tile,
    input  logic              load_ack,
    input  logic              load_done,
    output logic              addr_en,
    output logic              comp_bank,
    input  logic              done_tile,
    input  logic              out_last,
    output logic              busy,
    output logic              all_done,
    output logic              seq_err
);

    localparam logic [TILE_W:0] c_max_total = (TILE_W+1)'(MAX_TILES);
    localparam logic [TILE_W:0] c_one       = (TILE_W+1)'(1);

    fsm_state_t      r_state;
    fsm_state_t      w_state_next;
    bank_state_t     w_bank_st [2];
    logic [TILE_W:0] r_total;
    logic [TILE_W:0] r_load_idx;
    logic [TILE_W:0] r_comp_idx;
    logic [TILE_W:0] w_cfg_total;
    logic            r_load_busy;
    logic            r_addr_en;
    logic            r_seq_err;
    logic            w_load_req;
    logic            w_start_acc;
    logic            w_ack_acc;
    logic            w_ld_done_acc;
    logic            w_comp_start;
    logic            w_done_acc;
    logic            w_last;
    logic            w_out_bad;

    always_comb begin
        w_cfg_total = cfg_tile_total;
        if (cfg_tile_total == '0) begin
            w_cfg_total = c_one;
        end else if (cfg_tile_total > c_max_total) begin
            w_cfg_total = c_max_total;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A request needs its target bank EMPTY and no fill still in flight.
    always_comb begin
        w_state_next = r_state;
        w_load_req   = 1'b0;
        busy         = 1'b0;
        all_done     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_next = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                w_load_req = !r_load_busy && (r_load_idx < r_total) &&
                             (w_bank_st[r_load_idx[0]] == BANK_EMPTY);
                if (w_done_acc && w_last) w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                busy         = 1'b1;
                all_done     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_start_acc   = (r_state == ST_IDLE) && start;
    assign w_ack_acc     = w_load_req && load_ack;
    assign w_ld_done_acc = (r_state == ST_RUN) && r_load_busy && load_done;
    assign w_comp_start  = (r_state == ST_RUN) && !r_addr_en && (r_comp_idx < r_total) &&
                           (w_bank_st[r_comp_idx[0]] == BANK_FULL);
    assign w_done_acc    = (r_state == ST_RUN) && r_addr_en && done_tile;
    assign w_last        = (r_comp_idx == r_total - c_one);
    assign w_out_bad     = (r_state != ST_IDLE) &&
                           ((w_done_acc && w_last) ? !out_last : out_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_total     <= '0;
            r_load_idx  <= '0;
            r_comp_idx  <= '0;
            r_load_busy <= 1'b0;
            r_addr_en   <= 1'b0;
            r_seq_err   <= 1'b0;
        end else if (w_start_acc) begin
            r_total     <= w_cfg_total;
            r_load_idx  <= '0;
            r_comp_idx  <= '0;
            r_load_busy <= 1'b0;
            r_addr_en   <= 1'b0;
            r_seq_err   <= 1'b0;
        end else begin
            if (w_ack_acc) begin
                r_load_idx  <= r_load_idx + c_one;
                r_load_busy <= 1'b1;
            end else if (w_ld_done_acc) begin
                r_load_busy <= 1'b0;
            end
            if (w_comp_start) begin
                r_addr_en <= 1'b1;
            end else if (w_done_acc) begin
                r_addr_en  <= 1'b0;
                r_comp_idx <= r_comp_idx + c_one;
            end
            if (w_out_bad) r_seq_err <= 1'b1;
        end
    end

    // While a fill is outstanding the index has already advanced, so the
    // LOADING bank is the one opposite the current load index.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic c_sel = 1'(b);
        inbuff_bank_state u_bank (
            .clk           (clk),
            .rst_n         (rst_n),
            .clear         (w_start_acc),
            .load_accept   (w_ack_acc     && (r_load_idx[0] == c_sel)),
            .load_complete (w_ld_done_acc && (r_load_idx[0] != c_sel)),
            .comp_start    (w_comp_start  && (r_comp_idx[0] == c_sel)),
            .comp_done     (w_done_acc    && (r_comp_idx[0] == c_sel)),
            .state         (w_bank_st[b])
        );
    end

    assign load_req  = w_load_req;
    assign load_bank = r_load_idx[0];
    assign load_tile = r_load_idx[TILE_W-1:0];
    assign addr_en   = r_addr_en;
    assign comp_bank = r_comp_idx[0];
    assign seq_err   = r_seq_err;

endmodule
`default_nettype wire
